oam_dma_engine: RTL and testbench

OAM_DMA_ENGINE -- requirements
Module: oam_dma_engine

---
 rtl/oam_dma_engine_pkg.sv | 29 ++
 rtl/oam_dma_engine_if.sv | 43 ++++
 rtl/oam_dma_engine.sv | 111 +++++++++++
 tb/tb_oam_dma_engine.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_engine_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// oam_dma_engine_pkg -- shared OAM/DMA constants, FSM state type, page fold
// Rev 1.0
// ----------------------------------------------------------------------------
package oam_dma_engine_pkg;

  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int unsigned OAM_SIZE     = 160;
  localparam logic [7:0]  DMA_REG_ADDR = 8'h46;

  localparam logic [7:0]  ECHO_PAGE_LO = 8'hE0;
  localparam logic [7:0]  ECHO_FOLD    = 8'h20;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ADDR   = 3'd1,
    RD_DATA   = 3'd2,
    WR_ADDR   = 3'd3,
    WR_COMMIT = 3'd4
  } dma_state_e;

  // Pages E0-FF alias work RAM C0-DF, so the copy never sources from OAM or IO.
  function automatic logic [7:0] fold_page(input logic [7:0] page);
    return (page < ECHO_PAGE_LO) ? page : (page - ECHO_FOLD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_engine_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// oam_dma_if -- CPU trigger, memory-unit bus and status signals of the OAM DMA
// Rev 1.0
// ----------------------------------------------------------------------------
interface oam_dma_if;

  logic        start;
  logic [7:0]  src_page;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_oe;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;

  modport master (
    input  start,
    input  src_page,
    input  mem_rdata,
    output mem_addr,
    output mem_oe,
    output mem_we,
    output mem_wdata,
    output busy,
    output done
  );

  modport slave (
    output start,
    output src_page,
    output mem_rdata,
    input  mem_addr,
    input  mem_oe,
    input  mem_we,
    input  mem_wdata,
    input  busy,
    input  done
  );

endinterface
`default_nettype wire

// File: rtl/oam_dma_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// oam_dma_engine -- copies LENGTH bytes from {page,00} into OAM, 4 cycles/byte
// Rev 1.0
// ----------------------------------------------------------------------------
module oam_dma_engine
  import oam_dma_engine_pkg::*;
#(
  parameter int unsigned LENGTH   = OAM_SIZE,
  parameter logic [15:0] DST_BASE = OAM_BASE
) (
  input  logic      clk,
  input  logic      rst,
  oam_dma_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  dma_state_e  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;

  logic [15:0] rd_addr;
  logic [15:0] wr_addr;
  logic        last_byte;

  assign rd_addr   = {page_q, index_q};
  assign wr_addr   = DST_BASE + {8'h00, index_q};
  assign last_byte = (index_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      index_q <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    page_d        = page_q;
    index_d       = index_q;
    data_d        = data_q;
    done_d        = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_oe    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 8'h00;
    bus.busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
      end
      RD_ADDR: begin
        bus.mem_addr = rd_addr;
        bus.mem_oe   = 1'b1;
        state_d      = RD_DATA;
      end
      RD_DATA: begin
        bus.mem_addr = rd_addr;
        bus.mem_oe   = 1'b1;
        data_d       = bus.mem_rdata;
        state_d      = WR_ADDR;
      end
      WR_ADDR: begin
        bus.mem_addr  = wr_addr;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = data_q;
        state_d       = WR_COMMIT;
      end
      WR_COMMIT: begin
        bus.mem_addr  = wr_addr;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = data_q;
        if (last_byte) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          index_d = index_q + 8'd1;
          state_d = RD_ADDR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new trigger restarts from byte 0 in any state; the strobes of the
    // current cycle still go out, but the old transfer never reports done.
    if (bus.start) begin
      page_d  = fold_page(bus.src_page);
      index_d = 8'h00;
      state_d = RD_ADDR;
      done_d  = 1'b0;
    end
  end

  assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_oam_dma_engine -- table-driven transfers, abort/reset sequences, write scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_oam_dma_engine;
  import oam_dma_engine_pkg::*;

  localparam int          LEN      = 160;
  localparam logic [15:0] DST      = 16'hFE00;
  localparam logic [15:0] DST_LAST = DST + 16'(LEN - 1);
  localparam int          XFER_CYC = 4 * LEN;

  logic clk = 1'b0;
  logic rst;

  oam_dma_if bus();

  oam_dma_engine #(
    .LENGTH  (LEN),
    .DST_BASE(DST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory unit: untouched locations return a per-page background pattern.
  bit [7:0] mem [65536];
  bit       vld [65536];

  function automatic logic [7:0] bg(input logic [15:0] a);
    if (a[15:8] == 8'hC1) return a[7:0] ^ 8'h5A;
    return a[7:0] ^ (a[15:8] * 8'd37 + 8'd11);
  endfunction

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return vld[a] ? mem[a] : bg(a);
  endfunction

  always_comb bus.mem_rdata = vld[bus.mem_addr] ? mem[bus.mem_addr] : bg(bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      vld[bus.mem_addr] <= 1'b1;
    end
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0] src_page;
    logic [7:0] exp_page;
    int         exp_lat;
    int         exp_busy;
  } vec_t;

  wr_t        sb_q[$];
  vec_t       vecs [7];
  logic [7:0] exp_oam [LEN];
  logic [7:0] rd_page;
  int         checks;
  int         errors;
  int         done_cnt;
  int         rd_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic we_prev;
    wr_t  e;
    we_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_prev = 1'b0;
        continue;
      end
      if (bus.done) done_cnt++;
      if (bus.mem_oe && (bus.mem_addr[15:8] != rd_page)) rd_bad++;
      checks++;
      if ((bus.mem_oe && bus.mem_we) || (bus.done && bus.busy) ||
          (bus.mem_we && ((bus.mem_addr < DST) || (bus.mem_addr > DST_LAST)))) begin
        errors++;
        $display("FAIL bus_invariant: oe=%0b we=%0b done=%0b busy=%0b addr=%h", bus.mem_oe,
                 bus.mem_we, bus.done, bus.busy, bus.mem_addr);
      end
      if (bus.mem_we && !we_prev) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: got addr %h data %h expected none", bus.mem_addr,
                   bus.mem_wdata);
        end else begin
          e = sb_q.pop_front();
          if ((bus.mem_addr !== e.addr) || (bus.mem_wdata !== e.data)) begin
            errors++;
            $display("FAIL sb_write: got addr %h data %h expected addr %h data %h", bus.mem_addr,
                     bus.mem_wdata, e.addr, e.data);
          end
        end
      end
      we_prev = bus.mem_we;
    end
  endtask

  task automatic push_xfer(input logic [7:0] page);
    wr_t e;
    for (int i = 0; i < LEN; i++) begin
      e.addr = DST + 16'(i);
      e.data = bg({page, 8'(i)});
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [7:0] page);
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.src_page = page;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (cyc < XFER_CYC + 20) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) bcnt++;
      if (bus.done) break;
    end
  endtask

  task automatic check_oam(input string name, input logic [7:0] page);
    int bad;
    bad = 0;
    for (int i = 0; i < LEN; i++) begin
      if (mem_rd(DST + 16'(i)) !== bg({page, 8'(i)})) bad++;
      exp_oam[i] = bg({page, 8'(i)});
    end
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, bcnt, d0, bad;
    checks       = 0;
    errors       = 0;
    done_cnt     = 0;
    rd_bad       = 0;
    rd_page      = 8'h00;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.src_page = 8'h00;

    vecs[0] = '{src_page: 8'hC1, exp_page: 8'hC1, exp_lat: XFER_CYC + 1, exp_busy: XFER_CYC};
    vecs[1] = '{src_page: 8'hE3, exp_page: 8'hC3, exp_lat: XFER_CYC + 1, exp_busy: XFER_CYC};
    vecs[2] = '{src_page: 8'h80, exp_page: 8'h80, exp_lat: XFER_CYC + 1, exp_busy: XFER_CYC};
    vecs[3] = '{src_page: 8'h00, exp_page: 8'h00, exp_lat: XFER_CYC + 1, exp_busy: XFER_CYC};
    vecs[4] = '{src_page: 8'hDF, exp_page: 8'hDF, exp_lat: XFER_CYC + 1, exp_busy: XFER_CYC};
    vecs[5] = '{src_page: 8'hE0, exp_page: 8'hC0, exp_lat: XFER_CYC + 1, exp_busy: XFER_CYC};
    vecs[6] = '{src_page: 8'hFF, exp_page: 8'hDF, exp_lat: XFER_CYC + 1, exp_busy: XFER_CYC};

    fork
      monitor();
    join_none

    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_oe", 32'(bus.mem_oe), 32'd0);
    check("reset_we", 32'(bus.mem_we), 32'd0);
    check("reset_addr", 32'(bus.mem_addr), 32'h0000);
    check("reset_wdata", 32'(bus.mem_wdata), 32'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_addr", 32'(bus.mem_addr), 32'h0000);

    for (int v = 0; v < 7; v++) begin
      rd_page = vecs[v].exp_page;
      rd_bad  = 0;
      d0      = done_cnt;
      push_xfer(vecs[v].exp_page);
      pulse_start(vecs[v].src_page);
      wait_done(cyc, bcnt);
      check($sformatf("v%0d_done_latency", v), 32'(cyc), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_busy_cycles", v), 32'(bcnt), 32'(vecs[v].exp_busy));
      @(negedge clk);
      check($sformatf("v%0d_done_width", v), 32'(bus.done), 32'd0);
      check($sformatf("v%0d_done_count", v), 32'(done_cnt - d0), 32'd1);
      check($sformatf("v%0d_sb_drained", v), 32'(sb_q.size()), 32'd0);
      check($sformatf("v%0d_read_page", v), 32'(rd_bad), 32'd0);
      check_oam($sformatf("v%0d_oam", v), vecs[v].exp_page);
    end

    // Restart at byte 49 of a C0 transfer with page 80.
    rd_page = 8'hC0;
    rd_bad  = 0;
    d0      = done_cnt;
    push_xfer(8'hC0);
    pulse_start(8'hC0);
    repeat (199) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.src_page = 8'h80;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    check("abort_writes_before", 32'(sb_q.size()), 32'(LEN - 50));
    sb_q.delete();
    rd_page = 8'h80;
    push_xfer(8'h80);
    wait_done(cyc, bcnt);
    check("abort_done_latency", 32'(cyc), 32'(XFER_CYC + 1));
    @(negedge clk);
    check("abort_done_count", 32'(done_cnt - d0), 32'd1);
    check("abort_read_page", 32'(rd_bad), 32'd0);
    check_oam("abort_oam", 8'h80);

    // Restart landing on the final commit cycle.
    rd_page = 8'h81;
    rd_bad  = 0;
    d0      = done_cnt;
    push_xfer(8'h81);
    pulse_start(8'h81);
    repeat (639) @(posedge clk);
    #1;
    check("final_commit_we", 32'(bus.mem_we), 32'd1);
    check("final_commit_addr", 32'(bus.mem_addr), 32'(DST_LAST));
    bus.start    = 1'b1;
    bus.src_page = 8'h82;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    check("final_restart_busy", 32'(bus.busy), 32'd1);
    check("final_restart_done", 32'(bus.done), 32'd0);
    check("final_sb_drained", 32'(sb_q.size()), 32'd0);
    check_oam("final_first_oam", 8'h81);
    rd_page = 8'h82;
    push_xfer(8'h82);
    wait_done(cyc, bcnt);
    check("final_second_latency", 32'(cyc), 32'(XFER_CYC + 1));
    @(negedge clk);
    check("final_done_count", 32'(done_cnt - d0), 32'd1);
    check("final_read_page", 32'(rd_bad), 32'd0);
    check_oam("final_second_oam", 8'h82);

    // Asynchronous reset during byte 24's write-address cycle.
    rd_page = 8'hC1;
    rd_bad  = 0;
    d0      = done_cnt;
    push_xfer(8'hC1);
    pulse_start(8'hC1);
    repeat (98) @(posedge clk);
    #2;
    check("rst_pre_we", 32'(bus.mem_we), 32'd1);
    check("rst_pre_addr", 32'(bus.mem_addr), 32'(DST + 16'd24));
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_oe", 32'(bus.mem_oe), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'h0000);
    check("rst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    check("rst_writes_before", 32'(sb_q.size()), 32'(LEN - 24));
    sb_q.delete();
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_idle_busy", 32'(bus.busy), 32'd0);
    bad = 0;
    for (int i = 0; i < LEN; i++) begin
      if (i < 24) begin
        if (mem_rd(DST + 16'(i)) !== bg({8'hC1, 8'(i)})) bad++;
      end else if (i > 24) begin
        if (mem_rd(DST + 16'(i)) !== exp_oam[i]) bad++;
      end
    end
    check("rst_oam", 32'(bad), 32'd0);
    check("rst_read_page", 32'(rd_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
